// File: rtl/wb_arbiter.sv
// Writeback arbiter: one-entry slots for the ALU and load-data paths share the
// single register-file write port. Memory wins ties, but after MAX_MEM_STREAK
// consecutive memory grants with an ALU result waiting, the ALU is forced through.
module wb_arbiter #(
    parameter int XLEN           = 32,
    parameter int MAX_MEM_STREAK = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            reg_write,
    output logic [4:0]      wb_rd,
    output logic            mem_to_reg,
    output logic [XLEN-1:0] wb_mem_data,
    output logic [XLEN-1:0] wb_alu_result
);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_MEM_STREAK);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } slot_t;

    slot_t      alu_slot, mem_slot;
    logic       alu_full, mem_full;
    logic [3:0] streak;
    logic       grant_mem, grant_alu;

    // Memory wins unless the ALU has been starved for a full streak.
    always_comb begin
        grant_mem = mem_full && (!alu_full || streak != STREAK_MAX);
        grant_alu = alu_full && !grant_mem;
        alu_ready = !alu_full || grant_alu;
        mem_ready = !mem_full || grant_mem;
    end

    // Slot fill/drain; a granted slot may be refilled on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_full <= 1'b0;
            mem_full <= 1'b0;
            alu_slot <= '0;
            mem_slot <= '0;
        end else begin
            if (alu_valid && alu_ready) begin
                alu_full <= 1'b1;
                alu_slot <= '{rd: alu_rd, data: alu_result};
            end else if (grant_alu) begin
                alu_full <= 1'b0;
            end
            if (mem_valid && mem_ready) begin
                mem_full <= 1'b1;
                mem_slot <= '{rd: mem_rd, data: mem_data};
            end else if (grant_mem) begin
                mem_full <= 1'b0;
            end
        end
    end

    // Count memory grants taken while an ALU result waits; saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak <= '0;
        end else if (!alu_full || grant_alu) begin
            streak <= '0;
        end else if (grant_mem && streak != STREAK_MAX) begin
            streak <= streak + 4'd1;
        end
    end

    // Registered writeback port; the non-granted data bus keeps its old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write     <= 1'b0;
            wb_rd         <= '0;
            mem_to_reg    <= 1'b0;
            wb_mem_data   <= '0;
            wb_alu_result <= '0;
        end else if (grant_mem) begin
            reg_write   <= (mem_slot.rd != 5'd0);
            wb_rd       <= mem_slot.rd;
            mem_to_reg  <= 1'b1;
            wb_mem_data <= mem_slot.data;
        end else if (grant_alu) begin
            reg_write     <= (alu_slot.rd != 5'd0);
            wb_rd         <= alu_slot.rd;
            mem_to_reg    <= 1'b0;
            wb_alu_result <= alu_slot.data;
        end else begin
            reg_write <= 1'b0;
        end
    end
endmodule
